// File: rtl/vga_timing_gen.sv
// VGA timing generator: raster counters, sync generation, frame-aligned display
// enable and a latency-matched colour output stage.
//
// Stage 0 is the counter stage (o_x/o_y). Sync and blank information is carried
// through PIX_LAT registered stages so that sync and colour leave the block
// aligned. The pixel source answers a request for (o_x,o_y) PIX_LAT-1 cycles
// later; the final colour register adds the last stage. PIX_LAT must lie in 1..4.
module vga_timing_gen #(
   parameter int unsigned H_ACTIVE   = 640,
   parameter int unsigned H_FP       = 16,
   parameter int unsigned H_SYNC     = 96,
   parameter int unsigned H_BP       = 48,
   parameter int unsigned V_ACTIVE   = 480,
   parameter int unsigned V_FP       = 10,
   parameter int unsigned V_SYNC     = 2,
   parameter int unsigned V_BP       = 33,
   parameter bit          HSYNC_POL  = 1'b0,
   parameter bit          VSYNC_POL  = 1'b0,
   parameter int unsigned COLOR_BITS = 4,
   parameter int unsigned PIX_LAT    = 2,
   localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int unsigned XW        = $clog2(H_TOTAL),
   localparam int unsigned YW        = $clog2(V_TOTAL)
) (
   input  logic                  i_clk25Mhz,
   input  logic                  i_reset,
   input  logic                  i_cs,
   input  logic [COLOR_BITS-1:0] i_red,
   input  logic [COLOR_BITS-1:0] i_green,
   input  logic [COLOR_BITS-1:0] i_blue,
   output logic [XW-1:0]         o_x,
   output logic [YW-1:0]         o_y,
   output logic                  o_pixReq,
   output logic                  o_frameStart,
   output logic                  o_hsync,
   output logic                  o_vsync,
   output logic [COLOR_BITS-1:0] o_red,
   output logic [COLOR_BITS-1:0] o_green,
   output logic [COLOR_BITS-1:0] o_blue
);

   // Compare constants carry one spare bit so a sync window ending exactly at
   // a power-of-two total does not wrap.
   localparam logic [XW:0]   H_ACT_C   = (XW+1)'(H_ACTIVE);
   localparam logic [XW:0]   HS_BEG_C  = (XW+1)'(H_ACTIVE + H_FP);
   localparam logic [XW:0]   HS_END_C  = (XW+1)'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [XW-1:0] H_LAST_C  = XW'(H_TOTAL - 1);
   localparam logic [YW:0]   V_ACT_C   = (YW+1)'(V_ACTIVE);
   localparam logic [YW:0]   VS_BEG_C  = (YW+1)'(V_ACTIVE + V_FP);
   localparam logic [YW:0]   VS_END_C  = (YW+1)'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [YW-1:0] V_LAST_C  = YW'(V_TOTAL - 1);

   typedef enum logic [1:0] {StOff, StArm, StOn} en_state_e;

   logic [XW-1:0] h_cnt_q, h_cnt_d;
   logic [YW-1:0] v_cnt_q, v_cnt_d;
   logic          h_wrap;
   logic [XW:0]   hx;
   logic [YW:0]   vy;

   logic          act0, fs0, hs0, vs0, en0, show0, show_tap;

   en_state_e     state_q, state_d;

   logic [PIX_LAT-1:0] hs_q, vs_q;
   logic [PIX_LAT:0]   hs_all, vs_all;

   logic [COLOR_BITS-1:0] red_q, green_q, blue_q;

   // Next raster position: horizontal wraps every line, vertical steps on wrap.
   always_comb begin
      h_wrap  = (h_cnt_q == H_LAST_C);
      h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
      v_cnt_d = v_cnt_q;
      if (h_wrap) begin
         v_cnt_d = (v_cnt_q == V_LAST_C) ? '0 : v_cnt_q + 1'b1;
      end
   end

   // Raster counter registers; reset aborts the frame at once.
   always_ff @(posedge i_clk25Mhz or negedge i_reset) begin
      if (!i_reset) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
      end
   end

   // Stage-0 decode of the counter position.
   always_comb begin
      hx   = {1'b0, h_cnt_q};
      vy   = {1'b0, v_cnt_q};
      act0 = (hx < H_ACT_C) && (vy < V_ACT_C);
      fs0  = (h_cnt_q == '0) && (v_cnt_q == '0);
      hs0  = (hx >= HS_BEG_C) && (hx < HS_END_C);
      vs0  = (vy >= VS_BEG_C) && (vy < VS_END_C);
   end

   assign o_x = h_cnt_q;
   assign o_y = v_cnt_q;

   // Counters already sit at 0 during reset, so the strobes are masked by it.
   assign o_pixReq     = act0 & i_reset;
   assign o_frameStart = fs0 & i_reset;

   // Enable FSM next state; the display only turns on at pixel (0,0).
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StOff: if (i_cs) state_d = StArm;
         StArm: begin
            if (!i_cs) begin
               state_d = StOff;
            end else if (fs0) begin
               state_d = StOn;
            end
         end
         StOn:  if (!i_cs) state_d = StOff;
         default: state_d = StOff;
      endcase
   end

   // Enable FSM state register.
   always_ff @(posedge i_clk25Mhz or negedge i_reset) begin
      if (!i_reset) begin
         state_q <= StOff;
      end else begin
         state_q <= state_d;
      end
   end

   // Stage-0 enable; gating with i_cs makes disable immediate at stage 0.
   always_comb begin
      en0   = i_cs & ((state_q == StOn) | ((state_q == StArm) & fs0));
      show0 = act0 & en0;
   end

   assign hs_all = {hs_q, hs0};
   assign vs_all = {vs_q, vs0};

   // Sync pipeline: PIX_LAT stages of "asserted" flags.
   always_ff @(posedge i_clk25Mhz or negedge i_reset) begin
      if (!i_reset) begin
         hs_q <= '0;
         vs_q <= '0;
      end else begin
         hs_q <= hs_all[PIX_LAT-1:0];
         vs_q <= vs_all[PIX_LAT-1:0];
      end
   end

   assign o_hsync = hs_all[PIX_LAT] ? HSYNC_POL : ~HSYNC_POL;
   assign o_vsync = vs_all[PIX_LAT] ? VSYNC_POL : ~VSYNC_POL;

   // Active and enable travel together as one "show" flag; only their AND is
   // ever consumed. It is tapped one stage early to meet the colour register.
   if (PIX_LAT > 1) begin : g_show_pipe
      logic [PIX_LAT-2:0] show_q;
      logic [PIX_LAT-1:0] show_all;

      assign show_all = {show_q, show0};
      assign show_tap = show_all[PIX_LAT-1];

      // Show-flag delay line.
      always_ff @(posedge i_clk25Mhz or negedge i_reset) begin
         if (!i_reset) begin
            show_q <= '0;
         end else begin
            show_q <= show_all[PIX_LAT-2:0];
         end
      end
   end else begin : g_show_comb
      assign show_tap = show0;
   end

   // Colour register: source data when shown, black otherwise.
   always_ff @(posedge i_clk25Mhz or negedge i_reset) begin
      if (!i_reset) begin
         red_q   <= '0;
         green_q <= '0;
         blue_q  <= '0;
      end else if (show_tap) begin
         red_q   <= i_red;
         green_q <= i_green;
         blue_q  <= i_blue;
      end else begin
         red_q   <= '0;
         green_q <= '0;
         blue_q  <= '0;
      end
   end

   assign o_red   = red_q;
   assign o_green = green_q;
   assign o_blue  = blue_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. A default-geometry instance checks line timing
// against a hand-computed vector table; a small-geometry instance (16x10 total,
// PIX_LAT=3, positive hsync) exercises frame wrap, vsync, enable arming and
// mid-frame reset within a short run.
module tb_vga_timing_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       cs_d, cs_s;
   logic [3:0] r_in, g_in, b_in;

   logic [9:0] x_d, y_d;
   logic       pr_d, fs_d, hs_d, vs_d;
   logic [3:0] ro_d, go_d, bo_d;

   logic [3:0] x_s, y_s;
   logic       pr_s, fs_s, hs_s, vs_s;
   logic [3:0] ro_s, go_s, bo_s;

   vga_timing_gen dut_d (
      .i_clk25Mhz  (clk),
      .i_reset     (rst_n),
      .i_cs        (cs_d),
      .i_red       (r_in),
      .i_green     (g_in),
      .i_blue      (b_in),
      .o_x         (x_d),
      .o_y         (y_d),
      .o_pixReq    (pr_d),
      .o_frameStart(fs_d),
      .o_hsync     (hs_d),
      .o_vsync     (vs_d),
      .o_red       (ro_d),
      .o_green     (go_d),
      .o_blue      (bo_d)
   );

   vga_timing_gen #(
      .H_ACTIVE (8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE (6), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HSYNC_POL(1'b1), .VSYNC_POL(1'b0),
      .COLOR_BITS(4), .PIX_LAT(3)
   ) dut_s (
      .i_clk25Mhz  (clk),
      .i_reset     (rst_n),
      .i_cs        (cs_s),
      .i_red       (r_in),
      .i_green     (g_in),
      .i_blue      (b_in),
      .o_x         (x_s),
      .o_y         (y_s),
      .o_pixReq    (pr_s),
      .o_frameStart(fs_s),
      .o_hsync     (hs_s),
      .o_vsync     (vs_s),
      .o_red       (ro_s),
      .o_green     (go_s),
      .o_blue      (bo_s)
   );

   wire [35:0] obs_d = {x_d, y_d, pr_d, fs_d, hs_d, vs_d, ro_d, go_d, bo_d};
   wire [23:0] obs_s = {x_s, y_s, pr_s, fs_s, hs_s, vs_s, ro_s, go_s, bo_s};

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int n, input logic [63:0] got,
                      input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s n=%0d got=%h want=%h", name, n, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Small instance: 16 cycles/line, 10 lines/frame, outputs lag stage 0 by 3.
   // hsync asserted (high) for x in 10..12, vsync asserted (low) for y in 7..8,
   // active area x<8, y<6. Enabled stage-0 windows are fixed by the cs schedule.
   function automatic logic [23:0] exp_s(input int n, input bit ph1);
      int hx, vy, k, kx, ky;
      logic hs, vs, en;
      logic [11:0] rgb;
      hx  = n % 16;
      vy  = (n / 16) % 10;
      hs  = 1'b0;
      vs  = 1'b1;
      rgb = 12'h000;
      if (n >= 3) begin
         k  = n - 3;
         kx = k % 16;
         ky = (k / 16) % 10;
         if (kx >= 10 && kx < 13) hs = 1'b1;
         if (ky >= 7 && ky < 9) vs = 1'b0;
         en = ph1 ? (k >= 160) : ((k >= 160 && k < 197) || k >= 1440);
         if (en && kx < 8 && ky < 6) rgb = 12'hFA5;
      end
      return {4'(hx), 4'(vy), 1'(hx < 8 && vy < 6), 1'(hx == 0 && vy == 0), hs, vs, rgb};
   endfunction

   typedef struct {
      int          n;
      logic [9:0]  x;
      logic [9:0]  y;
      logic        pr;
      logic        fs;
      logic        hs;
      logic        vs;
      logic [11:0] rgb;
   } vec_t;

   localparam int NT = 12;
   vec_t tbl[NT];

   initial begin
      int ti;

      // Default instance, i_cs held 0: hsync low for stage-0 x in 656..751,
      // seen 2 cycles later; colour must stay black throughout.
      tbl[0]  = '{0,    10'd0,   10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 12'h000};
      tbl[1]  = '{1,    10'd1,   10'd0, 1'b1, 1'b0, 1'b1, 1'b1, 12'h000};
      tbl[2]  = '{2,    10'd2,   10'd0, 1'b1, 1'b0, 1'b1, 1'b1, 12'h000};
      tbl[3]  = '{639,  10'd639, 10'd0, 1'b1, 1'b0, 1'b1, 1'b1, 12'h000};
      tbl[4]  = '{640,  10'd640, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000};
      tbl[5]  = '{657,  10'd657, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000};
      tbl[6]  = '{658,  10'd658, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000};
      tbl[7]  = '{753,  10'd753, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000};
      tbl[8]  = '{754,  10'd754, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000};
      tbl[9]  = '{799,  10'd799, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000};
      tbl[10] = '{800,  10'd0,   10'd1, 1'b1, 1'b0, 1'b1, 1'b1, 12'h000};
      tbl[11] = '{1458, 10'd658, 10'd1, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000};

      rst_n = 1'b0;
      cs_d  = 1'b0;
      cs_s  = 1'b0;
      r_in  = 4'hF;
      g_in  = 4'hA;
      b_in  = 4'h5;

      // Reset held: both instances idle with syncs deasserted.
      repeat (10) begin
         tick();
         chk("rst_hold_d", 0, 64'(obs_d), 64'({10'd0, 10'd0, 4'b0011, 12'h000}));
         chk("rst_hold_s", 0, 64'(obs_s), 64'({4'd0, 4'd0, 4'b0001, 12'h000}));
      end

      rst_n = 1'b1;
      #1;

      // Run past nine small frames with cs pulsed on the small instance:
      // armed mid frame 0, on at frame 1, dropped at (5,2), re-armed for frame 9.
      ti = 0;
      for (int n = 0; n <= 1475; n++) begin
         if (n > 0) tick();
         cs_s = ((n >= 48 && n < 197) || n >= 1400);
         chk("small_run", n, 64'(obs_s), 64'(exp_s(n, 1'b0)));
         if (ti < NT && tbl[ti].n == n) begin
            chk("line_vec", n, 64'(obs_d),
                64'({tbl[ti].x, tbl[ti].y, tbl[ti].pr, tbl[ti].fs, tbl[ti].hs,
                     tbl[ti].vs, tbl[ti].rgb}));
            ti++;
         end
      end

      // Mid-frame reset while the small instance is showing colour: outputs
      // must return to idle without any clock edge.
      rst_n = 1'b0;
      cs_d  = 1'b1;
      cs_s  = 1'b1;
      #1;
      chk("rst_async_d", 0, 64'(obs_d), 64'({10'd0, 10'd0, 4'b0011, 12'h000}));
      chk("rst_async_s", 0, 64'(obs_s), 64'({4'd0, 4'd0, 4'b0001, 12'h000}));
      repeat (3) begin
         tick();
         chk("rst_mid_s", 0, 64'(obs_s), 64'({4'd0, 4'd0, 4'b0001, 12'h000}));
      end

      // Release with cs already high: frame 0 must stay black (re-arm via ARM),
      // colour appears from the next frame start onward.
      rst_n = 1'b1;
      #1;
      for (int n = 0; n <= 175; n++) begin
         if (n > 0) tick();
         chk("rearm_s", n, 64'(obs_s), 64'(exp_s(n, 1'b1)));
         chk("rearm_d", n, 64'(obs_d),
             64'({10'(n), 10'd0, 1'(n < 640), 1'(n == 0), 2'b11, 12'h000}));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch.
- H_SYNC, 96, hsync width.
- H_BP, 48, horizontal back porch.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch.
- V_SYNC, 2, vsync width.
- V_BP, 33, vertical back porch.
- HSYNC_POL, 0, asserted hsync level.
- VSYNC_POL, 0, asserted vsync level.
- COLOR_BITS, 4, bits per colour channel.
- PIX_LAT, 2, pixel pipeline latency in cycles (legal range 1..4).

REQ-002 Derived widths: H_TOTAL = sum of H_*, V_TOTAL = sum of V_*, XW = clog2(H_TOTAL), YW = clog2(V_TOTAL).

REQ-003 Ports (name, direction, width, meaning):
- i_clk25Mhz, in, 1, single pixel clock.
- i_reset, in, 1, asynchronous active-low reset.
- i_cs, in, 1, display enable.
- i_red / i_green / i_blue, in, COLOR_BITS each, pixel data from the source.
- o_x, out, XW, horizontal counter.
- o_y, out, YW, vertical counter.
- o_pixReq, out, 1, counter position is inside the active area.
- o_frameStart, out, 1, first-pixel pulse.
- o_hsync / o_vsync, out, 1 each, sync outputs.
- o_red / o_green / o_blue, out, COLOR_BITS each, colour outputs.

Function
REQ-004 hCnt SHALL count 0..H_TOTAL-1 each cycle and wrap to 0.
REQ-005 vCnt SHALL increment only when hCnt wraps, and SHALL wrap to 0 after V_TOTAL-1.
REQ-006 o_x/o_y SHALL equal hCnt/vCnt; this is the counter stage (stage 0).
REQ-007 o_pixReq SHALL be 1 iff hCnt<H_ACTIVE and vCnt<V_ACTIVE, combinational from the counters.
REQ-008 o_frameStart SHALL be 1 iff hCnt==0 and vCnt==0, giving a one-cycle pulse per frame.
REQ-009 Stage-0 hsync SHALL be asserted iff H_ACTIVE+H_FP <= hCnt < H_ACTIVE+H_FP+H_SYNC; vsync likewise with V_* on vCnt, independent of hCnt.
REQ-010 o_hsync, o_vsync and the stage-0 blank flag SHALL be delayed by exactly PIX_LAT registered stages, so outputs at edge t+PIX_LAT reflect stage 0 at t.
REQ-011 The pixel source SHALL present data for (o_x,o_y) PIX_LAT-1 cycles after they appear; PIX_LAT=1 means combinational data.
REQ-012 o_red/o_green/o_blue SHALL load i_red/i_green/i_blue when the delayed active flag and the delayed enable flag are both 1, and SHALL load 0 otherwise; colour is never nonzero during blanking.
REQ-013 The enable FSM SHALL have states OFF, ARM, ON.
REQ-014 OFF SHALL go to ARM when i_cs=1.
REQ-015 ARM SHALL go to ON in the cycle o_frameStart=1, and SHALL go to OFF if i_cs=0.
REQ-016 ON SHALL go to OFF when i_cs=0.
REQ-017 The enable flag SHALL be (state==ON), or (state==ARM and o_frameStart); enabling therefore only ever starts at pixel (0,0).
REQ-018 Disabling SHALL take effect at stage 0 in the same cycle i_cs is sampled 0 and SHALL reach the outputs PIX_LAT cycles later.
REQ-019 Sync timing SHALL be unaffected by i_cs and by the FSM state.

Reset
REQ-020 While i_reset=0, asynchronously: hCnt=vCnt=0; FSM=OFF; all pipeline stages cleared; o_hsync=~HSYNC_POL; o_vsync=~VSYNC_POL; RGB=0; o_pixReq=0; o_frameStart=0.
REQ-021 After i_reset rises, the first cycle SHALL show o_x=0, o_y=0, o_frameStart=1, and counting SHALL resume from there.
REQ-022 A reset asserted mid-frame SHALL abort the frame immediately, with no partial line completed.

Verification (defaults: H_TOTAL=800, V_TOTAL=525, PIX_LAT=2)
REQ-023 Hold i_reset=0 for 10 cycles -> o_hsync=o_vsync=1, RGB=0, o_x=o_y=0, o_pixReq=0 throughout.
REQ-024 Release reset with i_cs=0 -> o_hsync low for exactly 96 cycles, starting 2 cycles after o_x=656, repeating every 800 cycles; RGB stays 0.
REQ-025 Free-run 2 frames -> o_frameStart pulses exactly 420000 cycles apart; o_vsync low for 1600 cycles starting 2 cycles after o_y=490,o_x=0.
REQ-026 Raise i_cs at o_y=100 while the source drives RGB=F,A,5 -> RGB stays 0 until the next frameStart, then reads F,A,5 from 2 cycles after o_x=0,o_y=0 up to and including the output cycle of o_x=639.
REQ-027 Drop i_cs at o_x=300,o_y=200 while in ON -> RGB=0 from 2 cycles later onward, and hsync/vsync cadence is unchanged.
REQ-028 Assert i_reset=0 at o_y=300 -> all outputs reach their reset values with no clock edge needed; after release, o_x=o_y=0 and o_frameStart=1, and i_cs must re-arm through ARM.
